// File: rtl/hc595_display_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hc595_display_driver_if                                    |
// | Brief   : Request bus and board-level pins of the 74HC595 driver.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface hc595_display_driver_if #(
   parameter int NUM_DIGITS = 6
);
   logic                    update;
   logic [NUM_DIGITS*4-1:0] digit_val;
   logic [NUM_DIGITS-1:0]   dp_en;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    busy;
   logic                    done;
   logic                    all_bit_clk;
   logic                    all_nrst;
   logic                    control_data_ser;
   logic                    control_reg_clk;
   logic                    digit_data_ser;

   modport master (
      output update, digit_val, dp_en, blank,
      input  busy, done, all_bit_clk, all_nrst,
             control_data_ser, control_reg_clk, digit_data_ser
   );

   modport slave (
      input  update, digit_val, dp_en, blank,
      output busy, done, all_bit_clk, all_nrst,
             control_data_ser, control_reg_clk, digit_data_ser
   );
endinterface
`default_nettype wire

// File: rtl/hc595_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : hc595_display_driver                                       |
// | Brief   : Encodes digits to 7-seg bytes and clocks them into a       |
// |           shared-SRCLK 74HC595 control + digit register chain.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hc595_display_driver #(
   parameter int NUM_DIGITS = 6,
   parameter int CLK_DIV    = 1
) (
   input logic                   clk,
   input logic                   rst,
   hc595_display_driver_if.slave bus
);
   localparam int C_SLOT_W = $clog2(NUM_DIGITS + 1);
   localparam int C_NSLOT  = 1 << C_SLOT_W;
   localparam int C_DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(CLK_DIV - 1);
   localparam logic [C_SLOT_W-1:0] C_LAST_SLOT = C_SLOT_W'(NUM_DIGITS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_BIT_LO = 3'd2,
      S_BIT_HI = 3'd3,
      S_LAT_HI = 3'd4,
      S_LAT_LO = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t                  r_state;
   logic [C_DIV_W-1:0]      r_div;
   logic [2:0]              r_bit;
   logic [C_SLOT_W-1:0]     r_slot;
   logic [NUM_DIGITS*4-1:0] r_frame_val;
   logic [NUM_DIGITS-1:0]   r_frame_dp;
   logic [NUM_DIGITS-1:0]   r_frame_blank;
   logic                    r_pend;
   logic [NUM_DIGITS*4-1:0] r_pend_val;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_pend_blank;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_bit_clk;
   logic                    r_reg_clk;
   logic                    r_nrst;
   logic                    r_ctrl_ser;
   logic                    r_data_ser;

   logic [7:0]              w_ctrl_byte [C_NSLOT];
   logic [7:0]              w_data_byte [C_NSLOT];
   logic [C_SLOT_W-1:0]     w_next_slot;
   logic [2:0]              w_bit_next;
   logic                    w_div_last;

   function automatic logic [6:0] seg_pattern(input logic [3:0] v);
      case (v)
         4'h0:    seg_pattern = 7'h3F;
         4'h1:    seg_pattern = 7'h06;
         4'h2:    seg_pattern = 7'h5B;
         4'h3:    seg_pattern = 7'h4F;
         4'h4:    seg_pattern = 7'h66;
         4'h5:    seg_pattern = 7'h6D;
         4'h6:    seg_pattern = 7'h7D;
         4'h7:    seg_pattern = 7'h07;
         4'h8:    seg_pattern = 7'h7F;
         4'h9:    seg_pattern = 7'h6F;
         4'hA:    seg_pattern = 7'h77;
         4'hB:    seg_pattern = 7'h7C;
         4'hC:    seg_pattern = 7'h39;
         4'hD:    seg_pattern = 7'h5E;
         4'hE:    seg_pattern = 7'h79;
         default: seg_pattern = 7'h71;
      endcase
   endfunction

   // Slot table padded to a power of two; the padding entries act as clear slots.
   generate
      for (genvar i = 0; i < C_NSLOT; i++) begin : g_slot
         if (i < NUM_DIGITS) begin : g_digit
            assign w_ctrl_byte[i] = 8'h80 >> i;
            assign w_data_byte[i] = ~{r_frame_dp[i],
                                      r_frame_blank[i] ? 7'h00 : seg_pattern(r_frame_val[i*4 +: 4])};
         end else begin : g_clear
            assign w_ctrl_byte[i] = 8'h00;
            assign w_data_byte[i] = 8'hFF;
         end
      end
   endgenerate

   assign w_next_slot = r_slot + C_SLOT_W'(1);
   assign w_bit_next  = r_bit + 3'd1;
   assign w_div_last  = (r_div == C_DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_div         <= '0;
         r_bit         <= '0;
         r_slot        <= '0;
         r_frame_val   <= '0;
         r_frame_dp    <= '0;
         r_frame_blank <= '0;
         r_pend        <= 1'b0;
         r_pend_val    <= '0;
         r_pend_dp     <= '0;
         r_pend_blank  <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_bit_clk     <= 1'b0;
         r_reg_clk     <= 1'b0;
         r_nrst        <= 1'b0;
         r_ctrl_ser    <= 1'b0;
         r_data_ser    <= 1'b0;
      end else begin
         r_nrst <= 1'b1;
         r_done <= 1'b0;

         // busy is low in DONE, so a request there is handled by the DONE branch.
         if (bus.update && r_busy) begin
            r_pend       <= 1'b1;
            r_pend_val   <= bus.digit_val;
            r_pend_dp    <= bus.dp_en;
            r_pend_blank <= bus.blank;
         end

         case (r_state)
            S_IDLE: begin
               r_bit_clk  <= 1'b0;
               r_reg_clk  <= 1'b0;
               r_ctrl_ser <= 1'b0;
               r_data_ser <= 1'b0;
               if (bus.update) begin
                  r_frame_val   <= bus.digit_val;
                  r_frame_dp    <= bus.dp_en;
                  r_frame_blank <= bus.blank;
                  r_slot        <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_div      <= '0;
               r_bit      <= '0;
               r_ctrl_ser <= w_ctrl_byte[r_slot][7];
               r_data_ser <= w_data_byte[r_slot][7];
               r_state    <= S_BIT_LO;
            end
            S_BIT_LO: begin
               if (w_div_last) begin
                  r_div     <= '0;
                  r_bit_clk <= 1'b1;
                  r_state   <= S_BIT_HI;
               end else begin
                  r_div <= r_div + C_DIV_W'(1);
               end
            end
            S_BIT_HI: begin
               if (w_div_last) begin
                  r_div     <= '0;
                  r_bit_clk <= 1'b0;
                  if (r_bit == 3'd7) begin
                     r_reg_clk <= 1'b1;
                     r_state   <= S_LAT_HI;
                  end else begin
                     r_bit      <= w_bit_next;
                     r_ctrl_ser <= w_ctrl_byte[r_slot][3'd7 - w_bit_next];
                     r_data_ser <= w_data_byte[r_slot][3'd7 - w_bit_next];
                     r_state    <= S_BIT_LO;
                  end
               end else begin
                  r_div <= r_div + C_DIV_W'(1);
               end
            end
            S_LAT_HI: begin
               if (w_div_last) begin
                  r_div     <= '0;
                  r_reg_clk <= 1'b0;
                  r_state   <= S_LAT_LO;
               end else begin
                  r_div <= r_div + C_DIV_W'(1);
               end
            end
            S_LAT_LO: begin
               if (w_div_last) begin
                  r_div <= '0;
                  if (r_slot == C_LAST_SLOT) begin
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_ctrl_ser <= 1'b0;
                     r_data_ser <= 1'b0;
                     r_state    <= S_DONE;
                  end else begin
                     r_slot     <= w_next_slot;
                     r_bit      <= '0;
                     r_ctrl_ser <= w_ctrl_byte[w_next_slot][7];
                     r_data_ser <= w_data_byte[w_next_slot][7];
                     r_state    <= S_BIT_LO;
                  end
               end else begin
                  r_div <= r_div + C_DIV_W'(1);
               end
            end
            S_DONE: begin
               if (bus.update || r_pend) begin
                  // A request arriving this very cycle is newer than the buffer.
                  r_frame_val   <= bus.update ? bus.digit_val : r_pend_val;
                  r_frame_dp    <= bus.update ? bus.dp_en     : r_pend_dp;
                  r_frame_blank <= bus.update ? bus.blank     : r_pend_blank;
                  r_pend        <= 1'b0;
                  r_slot        <= '0;
                  r_busy        <= 1'b1;
                  r_state       <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy             = r_busy;
   assign bus.done             = r_done;
   assign bus.all_bit_clk      = r_bit_clk;
   assign bus.all_nrst         = r_nrst;
   assign bus.control_data_ser = r_ctrl_ser;
   assign bus.control_reg_clk  = r_reg_clk;
   assign bus.digit_data_ser   = r_data_ser;
endmodule
`default_nettype wire

// File: tb/tb_hc595_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_hc595_display_driver                                    |
// | Brief   : Drives two driver instances (CLK_DIV 1 and 3) into a       |
// |           74HC595 chain model and checks the latched digit bytes.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_hc595_display_driver;
   localparam int N   = 6;
   localparam int W   = N * 4;
   localparam int FR0 = 2 + (N + 1) * 18 * 1;
   localparam int FR1 = 2 + (N + 1) * 18 * 3;
   localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hc595_display_driver_if #(.NUM_DIGITS(N)) bus0 ();
   hc595_display_driver_if #(.NUM_DIGITS(N)) bus1 ();

   hc595_display_driver #(.NUM_DIGITS(N), .CLK_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
   hc595_display_driver #(.NUM_DIGITS(N), .CLK_DIV(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   // Board model: control + digit shift registers on SRCLK, digit i latches on a rising control Q[7-i].
   logic [7:0] c0_sh = '0, d0_sh = '0, c0_st = '0;
   logic [7:0] c1_sh = '0, d1_sh = '0, c1_st = '0;
   logic [7:0] d0_st [N];
   logic [7:0] d1_st [N];

   always @(posedge bus0.all_bit_clk or negedge bus0.all_nrst)
      if (!bus0.all_nrst) begin c0_sh <= '0; d0_sh <= '0; end
      else begin
         c0_sh <= {c0_sh[6:0], bus0.control_data_ser};
         d0_sh <= {d0_sh[6:0], bus0.digit_data_ser};
      end
   always @(posedge bus0.control_reg_clk) begin
      for (int i = 0; i < N; i++) if (!c0_st[7-i] && c0_sh[7-i]) d0_st[i] <= d0_sh;
      c0_st <= c0_sh;
   end

   always @(posedge bus1.all_bit_clk or negedge bus1.all_nrst)
      if (!bus1.all_nrst) begin c1_sh <= '0; d1_sh <= '0; end
      else begin
         c1_sh <= {c1_sh[6:0], bus1.control_data_ser};
         d1_sh <= {d1_sh[6:0], bus1.digit_data_ser};
      end
   always @(posedge bus1.control_reg_clk) begin
      for (int i = 0; i < N; i++) if (!c1_st[7-i] && c1_sh[7-i]) d1_st[i] <= d1_sh;
      c1_st <= c1_sh;
   end

   // Observers: done pulses, SER moving while SRCLK is high, SRCLK high-phase length.
   int   done0_cnt = 0, ser_bad0 = 0, ser_bad1 = 0, hi_bad1 = 0, rise1 = 0, hi_run1 = 0;
   logic pc0 = 1'b0, pd0 = 1'b0, pc1 = 1'b0, pd1 = 1'b0, pb1 = 1'b0;
   always @(negedge clk) begin
      if (bus0.done) done0_cnt++;
      if (bus0.all_bit_clk && (bus0.control_data_ser !== pc0 || bus0.digit_data_ser !== pd0)) ser_bad0++;
      if (bus1.all_bit_clk && (bus1.control_data_ser !== pc1 || bus1.digit_data_ser !== pd1)) ser_bad1++;
      pc0 = bus0.control_data_ser; pd0 = bus0.digit_data_ser;
      pc1 = bus1.control_data_ser; pd1 = bus1.digit_data_ser;
      if (bus1.all_bit_clk) begin
         if (!pb1) rise1++;
         hi_run1++;
      end else if (pb1) begin
         if (hi_run1 != 3) hi_bad1++;
         hi_run1 = 0;
      end
      pb1 = bus1.all_bit_clk;
   end

   function automatic logic [7:0] exp_wire(input logic [3:0] v, input logic dp, input logic bl);
      return ~{dp, bl ? 7'h00 : SEG_TAB[v]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done0(input int budget, output bit ok, output int t);
      ok = 1'b0; t = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus0.done) begin ok = 1'b1; t = cyc; break; end
      end
   endtask

   task automatic wait_done1(input int budget, output bit ok, output int t);
      ok = 1'b0; t = 0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (bus1.done) begin ok = 1'b1; t = cyc; break; end
      end
   endtask

   task automatic check_digits0(input string tag, input logic [W-1:0] v, input logic [N-1:0] dp,
                                input logic [N-1:0] bl);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_d%0d", tag, i), 32'(d0_st[i]), 32'(exp_wire(v[i*4 +: 4], dp[i], bl[i])));
      check({tag, "_ctrl"}, 32'(c0_st), 32'h0);
   endtask

   task automatic start0(input logic [W-1:0] v, input logic [N-1:0] dp, input logic [N-1:0] bl,
                         output int t0);
      bus0.digit_val = v; bus0.dp_en = dp; bus0.blank = bl; bus0.update = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus0.update = 1'b0;
   endtask

   task automatic run_frame0(input string tag, input logic [W-1:0] v, input logic [N-1:0] dp,
                             input logic [N-1:0] bl);
      int t0, td; bit ok;
      repeat (2) @(negedge clk);
      start0(v, dp, bl, t0);
      check({tag, "_busy"}, 32'(bus0.busy), 32'd1);
      wait_done0(FR0 + 20, ok, td);
      check({tag, "_done"}, 32'(ok), 32'd1);
      check({tag, "_lat"}, 32'(td - t0), 32'(FR0));
      check({tag, "_busy_dn"}, 32'(bus0.busy), 32'd0);
      check_digits0(tag, v, dp, bl);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] v, v2;
      logic [N-1:0] dp, bl;
      int t0, td, td2, dc, r0;
      bit ok;

      bus0.update = 1'b0; bus0.digit_val = '0; bus0.dp_en = '0; bus0.blank = '0;
      bus1.update = 1'b0; bus1.digit_val = '0; bus1.dp_en = '0; bus1.blank = '0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out0", 32'({bus0.busy, bus0.done, bus0.all_bit_clk, bus0.control_reg_clk,
                             bus0.control_data_ser, bus0.digit_data_ser, bus0.all_nrst}), 32'h0);
      check("rst_out1", 32'({bus1.busy, bus1.done, bus1.all_bit_clk, bus1.control_reg_clk,
                             bus1.control_data_ser, bus1.digit_data_ser, bus1.all_nrst}), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("nrst_rel", 32'({bus0.all_nrst, bus1.all_nrst}), 32'h3);
      check("idle_out", 32'({bus0.busy, bus0.all_bit_clk, bus0.control_reg_clk}), 32'h0);

      run_frame0("count", 24'h543210, 6'b000000, 6'b000000);
      run_frame0("dp_blank", 24'h543810, 6'b000100, 6'b010000);
      for (int k = 0; k < 5; k++) begin
         v = W'($urandom); dp = N'($urandom); bl = N'($urandom);
         run_frame0($sformatf("rnd%0d", k), v, dp, bl);
      end

      // Request while busy: frame 1 unchanged, frame 2 follows with no IDLE gap.
      repeat (2) @(negedge clk);
      v = W'($urandom); dp = N'($urandom); bl = N'($urandom);
      dc = done0_cnt;
      start0(v, dp, bl, t0);
      repeat (9) @(negedge clk);
      bus0.digit_val = 24'h999999; bus0.dp_en = '0; bus0.blank = '0; bus0.update = 1'b1;
      @(negedge clk);
      bus0.update = 1'b0;
      bus0.digit_val = W'($urandom); bus0.dp_en = N'($urandom); bus0.blank = N'($urandom);
      wait_done0(FR0 + 20, ok, td);
      check("b2b_done1", 32'(ok), 32'd1);
      check("b2b_lat1", 32'(td - t0), 32'(FR0));
      check("b2b_busy_dn", 32'(bus0.busy), 32'd0);
      check_digits0("b2b_f1", v, dp, bl);
      @(negedge clk);
      check("b2b_no_idle", 32'(bus0.busy), 32'd1);
      wait_done0(FR0 + 20, ok, td2);
      check("b2b_done2", 32'(ok), 32'd1);
      check("b2b_gap", 32'(td2 - td), 32'(FR0));
      check_digits0("b2b_f2", 24'h999999, '0, '0);
      repeat (FR0 + 20) @(negedge clk);
      check("b2b_done_cnt", 32'(done0_cnt - dc), 32'd2);

      // Reset mid-frame with a queued request: nothing more is sent.
      v = W'($urandom); v2 = W'($urandom);
      start0(v, '0, '0, t0);
      repeat (9) @(negedge clk);
      bus0.digit_val = v2; bus0.update = 1'b1;
      @(negedge clk);
      bus0.update = 1'b0;
      while (cyc < t0 + 50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out", 32'({bus0.all_nrst, bus0.busy, bus0.done, bus0.all_bit_clk,
                               bus0.control_reg_clk, bus0.control_data_ser, bus0.digit_data_ser}), 32'h0);
      check("midrst_shift", 32'({c0_sh, d0_sh}), 32'h0);
      rst = 1'b0;
      dc = done0_cnt;
      repeat (2 * FR0) @(negedge clk);
      check("midrst_no_done", 32'(done0_cnt - dc), 32'd0);
      check("midrst_idle", 32'({bus0.busy, bus0.all_bit_clk, bus0.control_reg_clk}), 32'h0);

      // Divided SRCLK instance.
      v = W'($urandom); dp = N'($urandom); bl = N'($urandom);
      r0 = rise1;
      bus1.digit_val = v; bus1.dp_en = dp; bus1.blank = bl; bus1.update = 1'b1;
      t0 = cyc;
      @(negedge clk);
      bus1.update = 1'b0;
      check("div3_busy", 32'(bus1.busy), 32'd1);
      wait_done1(FR1 + 20, ok, td);
      check("div3_done", 32'(ok), 32'd1);
      check("div3_lat", 32'(td - t0), 32'(FR1));
      check("div3_rises", 32'(rise1 - r0), 32'(8 * (N + 1)));
      for (int i = 0; i < N; i++)
         check($sformatf("div3_d%0d", i), 32'(d1_st[i]), 32'(exp_wire(v[i*4 +: 4], dp[i], bl[i])));
      check("div3_ctrl", 32'(c1_st), 32'h0);
      repeat (4) @(negedge clk);

      check("div3_hi_phase", 32'(hi_bad1), 32'd0);
      check("ser_stable0", 32'(ser_bad0), 32'd0);
      check("ser_stable1", 32'(ser_bad1), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
